// File: rtl/adc_trigger_capture.sv
// ADC capture controller: arm, level/edge trigger, bounded sample stream into a FIFO write port.
// Optional pre-trigger history when ADC_TRIGGER_CAPTURE_PRETRIG_EN is defined.
module adc_trigger_capture #(
   parameter int ADC_WIDTH   = 10,
   parameter int CNT_WIDTH   = 16,
   parameter int PRE_SAMPLES = 8
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic [ADC_WIDTH-1:0] adc_data_i,
   input  logic                 adc_or_i,
   input  logic                 trigger_i,
   input  logic [1:0]           trig_mode_i,
   input  logic                 trig_wait_i,
   input  logic                 arm_i,
   input  logic                 abort_i,
   input  logic [CNT_WIDTH-1:0] samples_i,
   input  logic                 fifo_full_i,
   output logic [ADC_WIDTH:0]   fifo_data_o,
   output logic                 fifo_wr_en_o,
   output logic                 armed_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 overflow_o,
   output logic [CNT_WIDTH-1:0] sample_count_o
);

   localparam int DW = ADC_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONES = {CNT_WIDTH{1'b1}};
   localparam logic [DW-1:0]        DATA_ZERO = {DW{1'b0}};

   if (PRE_SAMPLES < 1 || PRE_SAMPLES > 255) begin : g_pre_range
      $error("PRE_SAMPLES must be within 1..255");
   end

   typedef enum logic [2:0] {
      ST_IDLE          = 3'd0,
      ST_WAIT_INACTIVE = 3'd1,
      ST_ARMED         = 3'd2,
      ST_CAPTURE       = 3'd3,
      ST_DONE          = 3'd4
   } state_t;

   state_t                state_r, state_nxt_s;
   logic [ADC_WIDTH-1:0]  s1_data_r;
   logic                  s1_or_r, s1_trig_r, s2_trig_r;
   logic [CNT_WIDTH-1:0]  target_r, target_nxt_s, count_r, count_nxt_s;
   logic                  overflow_r, overflow_nxt_s, wr_en_r, wr_en_nxt_s;
   logic                  done_r, armed_r, busy_r;
   logic [DW-1:0]         data_r, data_nxt_s, src_s;
   logic                  level_mode_s, trig_active_s, trig_event_s, arm_ready_s, target_hit_s;

   // Input stage: s1 samples the pins, s2 keeps the previous trigger for edge detection
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         s1_data_r <= {ADC_WIDTH{1'b0}};
         s1_or_r   <= 1'b0;
         s1_trig_r <= 1'b0;
         s2_trig_r <= 1'b0;
      end else begin
         s1_data_r <= adc_data_i;
         s1_or_r   <= adc_or_i;
         s1_trig_r <= trigger_i;
         s2_trig_r <= s1_trig_r;
      end
   end

   // Trigger decode; trig_mode_i[0] is the active level / edge destination level
   always_comb begin
      level_mode_s  = ~trig_mode_i[1];
      trig_active_s = (s1_trig_r == trig_mode_i[0]);
      if (level_mode_s) begin
         trig_event_s = trig_active_s;
      end else begin
         trig_event_s = trig_active_s && (s2_trig_r != trig_mode_i[0]);
      end
   end

`ifdef ADC_TRIGGER_CAPTURE_PRETRIG_EN
   localparam int PTR_W = (PRE_SAMPLES > 1) ? $clog2(PRE_SAMPLES) : 1;

   logic [DW-1:0]    ring_r [PRE_SAMPLES];
   logic [PTR_W-1:0] ptr_r;
   logic [7:0]       warm_r;

   // Delay line: the slot read this cycle is the oldest entry, overwritten at the same edge
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < PRE_SAMPLES; i++) begin
            ring_r[i] <= DATA_ZERO;
         end
         ptr_r  <= {PTR_W{1'b0}};
         warm_r <= 8'd0;
      end else begin
         ring_r[ptr_r] <= {s1_or_r, s1_data_r};
         if (ptr_r == PTR_W'(PRE_SAMPLES - 1)) begin
            ptr_r <= {PTR_W{1'b0}};
         end else begin
            ptr_r <= ptr_r + PTR_W'(1);
         end
         if (warm_r != 8'(PRE_SAMPLES)) begin
            warm_r <= warm_r + 8'd1;
         end else begin
            warm_r <= warm_r;
         end
      end
   end

   assign src_s       = ring_r[ptr_r];
   assign arm_ready_s = (warm_r == 8'(PRE_SAMPLES));
`else
   assign src_s       = {s1_or_r, s1_data_r};
   assign arm_ready_s = 1'b1;
`endif

   // Next-state and next-output logic; abort outranks full, which outranks target reached
   always_comb begin
      state_nxt_s    = state_r;
      target_nxt_s   = target_r;
      count_nxt_s    = count_r;
      overflow_nxt_s = overflow_r;
      wr_en_nxt_s    = 1'b0;
      data_nxt_s     = data_r;
      target_hit_s   = (target_r != CNT_ZERO) && (count_r == target_r);
      if (abort_i) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (arm_i && arm_ready_s) begin
                  target_nxt_s   = samples_i;
                  count_nxt_s    = CNT_ZERO;
                  overflow_nxt_s = 1'b0;
                  if (trig_wait_i && level_mode_s && trig_active_s) begin
                     state_nxt_s = ST_WAIT_INACTIVE;
                  end else begin
                     state_nxt_s = ST_ARMED;
                  end
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_WAIT_INACTIVE: begin
               if (!trig_active_s) begin
                  state_nxt_s = ST_ARMED;
               end else begin
                  state_nxt_s = ST_WAIT_INACTIVE;
               end
            end
            ST_ARMED: begin
               if (trig_event_s) begin
                  state_nxt_s = ST_CAPTURE;
                  wr_en_nxt_s = 1'b1;
                  data_nxt_s  = src_s;
                  count_nxt_s = CNT_WIDTH'(1);
               end else begin
                  state_nxt_s = ST_ARMED;
               end
            end
            ST_CAPTURE: begin
               if (fifo_full_i) begin
                  state_nxt_s = ST_DONE;
                  if (target_r != CNT_ZERO) begin
                     overflow_nxt_s = 1'b1;
                  end else begin
                     overflow_nxt_s = overflow_r;
                  end
               end else if (target_hit_s) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  wr_en_nxt_s = 1'b1;
                  data_nxt_s  = src_s;
                  if (count_r != CNT_ONES) begin
                     count_nxt_s = count_r + CNT_WIDTH'(1);
                  end else begin
                     count_nxt_s = count_r;
                  end
               end
            end
            ST_DONE: begin
               state_nxt_s = ST_IDLE;
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // State and registered outputs; status flags decoded from the next state
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r    <= ST_IDLE;
         target_r   <= CNT_ZERO;
         count_r    <= CNT_ZERO;
         overflow_r <= 1'b0;
         wr_en_r    <= 1'b0;
         data_r     <= DATA_ZERO;
         armed_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         target_r   <= target_nxt_s;
         count_r    <= count_nxt_s;
         overflow_r <= overflow_nxt_s;
         wr_en_r    <= wr_en_nxt_s;
         data_r     <= data_nxt_s;
         armed_r    <= (state_nxt_s == ST_ARMED);
         busy_r     <= (state_nxt_s != ST_IDLE);
         done_r     <= (state_nxt_s == ST_DONE);
      end
   end

   assign fifo_data_o    = data_r;
   assign fifo_wr_en_o   = wr_en_r;
   assign armed_o        = armed_r;
   assign busy_o         = busy_r;
   assign done_o         = done_r;
   assign overflow_o     = overflow_r;
   assign sample_count_o = count_r;

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Randomised + directed bench for adc_trigger_capture, compared every cycle against a
// history-based reference model (writes derived from edge offsets since the trigger).
module tb_adc_trigger_capture;

   localparam int P    = 8;
   localparam int MAXC = 20000;
   localparam int CMAX = 65535;

   logic        clk = 1'b0;
   logic        reset_n_i = 1'b0;
   logic [9:0]  adc_data_i = 10'd0;
   logic        adc_or_i = 1'b0;
   logic        trigger_i = 1'b0;
   logic [1:0]  trig_mode_i = 2'b00;
   logic        trig_wait_i = 1'b0;
   logic        arm_i = 1'b0;
   logic        abort_i = 1'b0;
   logic [15:0] samples_i = 16'd0;
   logic        fifo_full_i = 1'b0;
   logic [10:0] fifo_data_o;
   logic        fifo_wr_en_o, armed_o, busy_o, done_o, overflow_o;
   logic [15:0] sample_count_o;

   adc_trigger_capture #(.ADC_WIDTH(10), .CNT_WIDTH(16), .PRE_SAMPLES(P)) dut (
      .clk_i(clk), .reset_n_i(reset_n_i), .adc_data_i(adc_data_i), .adc_or_i(adc_or_i),
      .trigger_i(trigger_i), .trig_mode_i(trig_mode_i), .trig_wait_i(trig_wait_i),
      .arm_i(arm_i), .abort_i(abort_i), .samples_i(samples_i), .fifo_full_i(fifo_full_i),
      .fifo_data_o(fifo_data_o), .fifo_wr_en_o(fifo_wr_en_o), .armed_o(armed_o),
      .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o),
      .sample_count_o(sample_count_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [10:0] h_smp [0:MAXC-1];
   bit          h_trg [0:MAXC-1];
   int          n_edge = 0;
   int          last_rst = 0;
   bit          m_wr, m_armed, m_wait, m_cap, m_done, m_ovf;
   logic [10:0] m_data = 11'd0;
   int          m_count = 0, m_start = 0, m_target = 0;

   // everything recorded before the most recent reset reads back as zero
   function automatic logic [10:0] smp_at(input int k);
      if (k < last_rst || k < 0) return 11'd0;
      return h_smp[k];
   endfunction

   function automatic bit trg_at(input int k);
      if (k < last_rst || k < 0) return 1'b0;
      return h_trg[k];
   endfunction

   always @(posedge clk) begin : model
      bit t1, t2, lvl, act, ev, ready, done_prev;
      logic [10:0] src;
      int written;
      n_edge++;
      done_prev = m_done;
      m_done = 1'b0;
      m_wr = 1'b0;
      if (!reset_n_i) begin
         h_smp[n_edge] = 11'd0; h_trg[n_edge] = 1'b0; last_rst = n_edge;
         m_armed = 1'b0; m_wait = 1'b0; m_cap = 1'b0; m_ovf = 1'b0;
         m_data = 11'd0; m_count = 0; m_target = 0;
      end else begin
         h_smp[n_edge] = {adc_or_i, adc_data_i};
         h_trg[n_edge] = trigger_i;
         t1  = trg_at(n_edge - 1);
         t2  = trg_at(n_edge - 2);
         lvl = !trig_mode_i[1];
         act = trig_mode_i[0];
         ev  = lvl ? (t1 == act) : (t1 == act && t2 != act);
`ifdef ADC_TRIGGER_CAPTURE_PRETRIG_EN
         src   = smp_at(n_edge - 1 - P);
         ready = (n_edge - last_rst) > P;
`else
         src   = smp_at(n_edge - 1);
         ready = 1'b1;
`endif
         if (abort_i) begin
            m_armed = 1'b0; m_wait = 1'b0; m_cap = 1'b0;
         end else if (m_cap) begin
            written = n_edge - m_start;
            if (fifo_full_i) begin
               m_cap = 1'b0; m_done = 1'b1;
               if (m_target != 0) m_ovf = 1'b1;
            end else if (m_target != 0 && written == m_target) begin
               m_cap = 1'b0; m_done = 1'b1;
            end else begin
               m_wr = 1'b1; m_data = src;
               m_count = (written + 1 > CMAX) ? CMAX : written + 1;
            end
         end else if (done_prev) begin
            // the done cycle always returns to idle
         end else if (m_armed) begin
            if (ev) begin
               m_armed = 1'b0; m_cap = 1'b1; m_start = n_edge;
               m_wr = 1'b1; m_data = src; m_count = 1;
            end
         end else if (m_wait) begin
            if (t1 != act) begin m_wait = 1'b0; m_armed = 1'b1; end
         end else if (arm_i && ready) begin
            m_target = int'(samples_i); m_count = 0; m_ovf = 1'b0;
            if (trig_wait_i && lvl && t1 == act) m_wait = 1'b1;
            else m_armed = 1'b1;
         end
      end
   end

   // Compare every cycle plus log writes/done pulses for directed expectations
   logic [10:0] wr_log[$];
   int done_cnt = 0;
   int first_wr_cyc = 0;

   always @(negedge clk) begin
      if (n_edge > 0) begin
         chk("wr_en", int'(fifo_wr_en_o), int'(m_wr));
         chk("data", int'(fifo_data_o), int'(m_data));
         chk("armed", int'(armed_o), int'(m_armed));
         chk("busy", int'(busy_o), int'(m_armed | m_wait | m_cap | m_done));
         chk("done", int'(done_o), int'(m_done));
         chk("overflow", int'(overflow_o), int'(m_ovf));
         chk("count", int'(sample_count_o), m_count);
      end
      if (fifo_wr_en_o) begin
         if (wr_log.size() == 0) first_wr_cyc = n_edge;
         wr_log.push_back(fifo_data_o);
      end
      if (done_o) done_cnt++;
   end

   // ---------------- stimulus ----------------
   bit rand_data = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_data) begin
         adc_data_i = 10'($urandom);
         adc_or_i   = 1'($urandom);
      end else begin
         adc_data_i = adc_data_i + 10'd1;
         adc_or_i   = 1'b0;
      end
   endtask

   task automatic arm_pulse();
      arm_i = 1'b1;
      tick();
      arm_i = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int d0 = done_cnt;
      int i = 0;
      while (done_cnt == d0 && i < budget) begin tick(); i++; end
      chk(nm, done_cnt - d0, 1);
   endtask

   task automatic wait_writes(input string nm, input int k, input int budget);
      int i = 0;
      while (wr_log.size() < k && i < budget) begin tick(); i++; end
      if (wr_log.size() < k) chk(nm, wr_log.size(), k);
   endtask

   task automatic wait_data(input logic [9:0] v);
      int i = 0;
      while (adc_data_i != v && i < 1100) begin tick(); i++; end
   endtask

   initial begin
      int trig_cyc, d0;
      repeat (3) tick();
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_data", int'(fifo_data_o), 0);
      chk("rst_count", int'(sample_count_o), 0);
      reset_n_i = 1'b1;
      repeat (P + 4) tick();

      // level capture, ramp data, trigger coincident with sample 20
      trig_mode_i = 2'b01; trig_wait_i = 1'b0; samples_i = 16'd4; trigger_i = 1'b0;
      arm_pulse();
      chk("lvl_armed", int'(armed_o), 1);
      adc_data_i = 10'd16;
      wait_data(10'd20);
      wr_log.delete();
      trigger_i = 1'b1;
      trig_cyc = n_edge;
      wait_done("lvl_done", 20);
      chk("lvl_nwr", wr_log.size(), 4);
      for (int i = 0; i < 4 && i < wr_log.size(); i++) chk("lvl_val", int'(wr_log[i]), 20 + i);
      chk("lvl_latency", first_wr_cyc - trig_cyc, 2);
      tick();
      chk("lvl_idle", int'(busy_o), 0);

      // wait-inactive: trigger already high when armed
      trig_wait_i = 1'b1; samples_i = 16'd3;
      tick(); tick();
      arm_pulse();
      wr_log.delete();
      repeat (5) tick();
      chk("wait_armed_hi", int'(armed_o), 0);
      chk("wait_busy", int'(busy_o), 1);
      trigger_i = 1'b0;
      tick();
      chk("wait_armed_1", int'(armed_o), 0);
      tick();
      chk("wait_armed_lo", int'(armed_o), 1);
      chk("wait_nowr", wr_log.size(), 0);
      trigger_i = 1'b1;
      wait_done("wait_done", 20);
      chk("wait_nwr", wr_log.size(), 3);

      // rising edge: trigger high at arm must not capture
      trig_mode_i = 2'b11; trig_wait_i = 1'b0;
      arm_pulse();
      wr_log.delete();
      repeat (10) tick();
      chk("rise_nowr", wr_log.size(), 0);
      trigger_i = 1'b0; tick();
      trigger_i = 1'b1;
      wait_done("rise_done", 20);
      chk("rise_nwr", wr_log.size(), 3);

      // falling edge only
      trig_mode_i = 2'b10; trigger_i = 1'b0;
      tick(); tick();
      arm_pulse();
      wr_log.delete();
      repeat (3) tick();
      trigger_i = 1'b1;
      repeat (5) tick();
      chk("fall_nowr", wr_log.size(), 0);
      trigger_i = 1'b0;
      wait_done("fall_done", 20);
      chk("fall_nwr", wr_log.size(), 3);

      // FIFO full before nonzero target
      rand_data = 1'b1;
      trig_mode_i = 2'b11; samples_i = 16'd100;
      arm_pulse();
      wr_log.delete();
      trigger_i = 1'b1;
      wait_writes("full_wait", 50, 200);
      fifo_full_i = 1'b1;
      tick();
      chk("full_wr", int'(fifo_wr_en_o), 0);
      chk("full_done", int'(done_o), 1);
      chk("full_ovf", int'(overflow_o), 1);
      fifo_full_i = 1'b0;
      repeat (3) tick();
      chk("full_ovf_sticky", int'(overflow_o), 1);

      // FIFO full with target 0 (normal end)
      samples_i = 16'd0; trigger_i = 1'b0;
      tick();
      arm_pulse();
      chk("z_ovf_clr", int'(overflow_o), 0);
      wr_log.delete();
      trigger_i = 1'b1;
      wait_writes("z_wait", 30, 200);
      fifo_full_i = 1'b1;
      tick();
      chk("z_done", int'(done_o), 1);
      chk("z_ovf", int'(overflow_o), 0);
      fifo_full_i = 1'b0;
      tick();

      // abort mid-capture
      samples_i = 16'd20; trigger_i = 1'b0;
      tick();
      arm_pulse();
      wr_log.delete();
      trigger_i = 1'b1;
      wait_writes("ab_wait", 5, 50);
      d0 = done_cnt;
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("ab_wr", int'(fifo_wr_en_o), 0);
      chk("ab_busy", int'(busy_o), 0);
      repeat (25) tick();
      chk("ab_nodone", done_cnt - d0, 0);

      // arm while busy ignored, then reset mid-capture
      samples_i = 16'd30; trigger_i = 1'b0;
      tick();
      arm_pulse();
      wr_log.delete();
      trigger_i = 1'b1;
      wait_writes("rs_wait", 3, 50);
      samples_i = 16'd5;
      arm_pulse();
      repeat (8) tick();
      chk("rs_busy", int'(busy_o), 1);
      reset_n_i = 1'b0;
      tick();
      reset_n_i = 1'b1;
      chk("rs_wr", int'(fifo_wr_en_o), 0);
      chk("rs_busy0", int'(busy_o), 0);
      chk("rs_data", int'(fifo_data_o), 0);
      chk("rs_count", int'(sample_count_o), 0);
      repeat (P + 4) tick();

`ifdef ADC_TRIGGER_CAPTURE_PRETRIG_EN
      rand_data = 1'b0;
      trig_mode_i = 2'b11; samples_i = 16'd12; trigger_i = 1'b0;
      arm_pulse();
      adc_data_i = 10'd30;
      wait_data(10'd40);
      wr_log.delete();
      trigger_i = 1'b1;
      wait_done("pre_done", 40);
      chk("pre_nwr", wr_log.size(), 12);
      for (int i = 0; i < 12 && i < wr_log.size(); i++) chk("pre_val", int'(wr_log[i]), 32 + i);
      rand_data = 1'b1;
`endif

      // randomised operation
      for (int it = 0; it < 400; it++) begin
         trig_mode_i = 2'($urandom);
         trig_wait_i = 1'($urandom);
         samples_i = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
         arm_i = 1'b1;
         for (int c = 0; c < 20; c++) begin
            tick();
            arm_i = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) trigger_i = ~trigger_i;
            fifo_full_i = ($urandom_range(0, 15) == 0);
            abort_i = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 31) == 0) trig_mode_i = 2'($urandom);
            reset_n_i = ($urandom_range(0, 199) != 0);
         end
      end
      arm_i = 1'b0; abort_i = 1'b0; fifo_full_i = 1'b0; reset_n_i = 1'b1;
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
